// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control unit: register index width and FSM states.
package pipeline_ctrl_pkg;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} pipe_ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use detector: a load in EX whose destination feeds an ID-stage source.
import pipeline_ctrl_pkg::*;

module hazard_unit (
  input  logic     load_ex,
  input  regbits_t rt_ex,
  input  regbits_t rs_id,
  input  regbits_t rt_id,
  output logic     lu
);
  // $zero never carries a real dependency.
  assign lu = load_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush/halt controller.
// Optional PIPELINE_CTRL_PERF_EN adds saturating stall and squash counters.
//
// state    | meaning
// RUN      | normal issue, hazard arbitration
// MEM_WAIT | data access outstanding, pipeline frozen
// HALTED   | halt retired, only RST leaves
import pipeline_ctrl_pkg::*;

module pipeline_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_EX_MEM,
  input  logic        dWEN_EX_MEM,
  input  logic        dREN_ID_EX,
  input  logic [4:0]  Rt_ID_EX,
  input  logic [4:0]  Rs_IF_ID,
  input  logic [4:0]  Rt_IF_ID,
  input  logic        redirect_EX_MEM,
  input  logic        halt_EX_MEM,
  output logic        pc_enable,
  output logic        enable_IF_ID,
  output logic        enable_ID_EX,
  output logic        enable_EX_MEM,
  output logic        enable_MEM_WB,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        flush_EX_MEM,
  output logic        flush_MEM_WB,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] squash_count,
`endif
  output logic        halt
);
  pipe_ctrl_state_t state, state_next;
  logic memreq, lu, redirect_taken;

  assign memreq = dREN_EX_MEM || dWEN_EX_MEM;

  hazard_unit u_hazard (
    .load_ex (dREN_ID_EX),
    .rt_ex   (Rt_ID_EX),
    .rs_id   (Rs_IF_ID),
    .rt_id   (Rt_IF_ID),
    .lu      (lu)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    pc_enable      = 1'b0;
    enable_IF_ID   = 1'b0;
    enable_ID_EX   = 1'b0;
    enable_EX_MEM  = 1'b0;
    enable_MEM_WB  = 1'b0;
    flush_IF_ID    = 1'b0;
    flush_ID_EX    = 1'b0;
    flush_EX_MEM   = 1'b0;
    flush_MEM_WB   = 1'b0;
    halt           = 1'b0;
    redirect_taken = 1'b0;
    if (RST) begin
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (halt_EX_MEM) begin
            enable_MEM_WB = 1'b1;
            flush_EX_MEM  = 1'b1;
            state_next    = HALTED;
          end else if (memreq && !dhit) begin
            flush_MEM_WB = 1'b1;
            state_next   = MEM_WAIT;
          end else if (memreq && !ihit) begin
            // Data finished but fetch still pending: retire the access, bubble ID/EX.
            enable_MEM_WB = 1'b1;
            enable_EX_MEM = 1'b1;
            flush_ID_EX   = 1'b1;
          end else if (!ihit) begin
            flush_MEM_WB = 1'b1;
          end else if (redirect_EX_MEM) begin
            redirect_taken = 1'b1;
            pc_enable      = 1'b1;
            enable_IF_ID   = 1'b1;
            enable_ID_EX   = 1'b1;
            enable_EX_MEM  = 1'b1;
            enable_MEM_WB  = 1'b1;
            flush_IF_ID    = 1'b1;
            flush_ID_EX    = 1'b1;
            flush_EX_MEM   = 1'b1;
          end else if (lu) begin
            flush_ID_EX   = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
          end else begin
            pc_enable     = 1'b1;
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dhit) begin
            flush_MEM_WB = 1'b1;
          end else begin
            enable_MEM_WB = 1'b1;
            enable_EX_MEM = 1'b1;
            flush_ID_EX   = 1'b1;
            state_next    = RUN;
          end
        end
        HALTED: halt = 1'b1;
        default: state_next = RUN;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
      squash_count <= '0;
    end else if (state != HALTED) begin
      if (!pc_enable && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_taken && squash_count != 32'hFFFF_FFFF)
        squash_count <= squash_count + 32'd1;
    end
  end
`endif
endmodule
